ram_refresh_timer: RTL and testbench



---
 rtl/ram_pkg.sv | 18 +
 rtl/cbr_detect.sv | 21 ++
 rtl/ram_refresh_timer.sv | 112 +++++++++++
 tb/tb_ram_refresh_timer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared refresh-timer definitions: FSM state encoding and default timing constants.
// Also used by the DRAM controller bench so both agree on the refresh cadence.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    URG  = 2'd2,
    GAP  = 2'd3
  } refState_t;

  localparam int DEF_REF_PERIOD = 375;  // 15 us at 25 MHz
  localparam int DEF_URG_DELAY  = 64;
  localparam int DEF_URG_DEBT   = 2;
  localparam int DEF_MAX_DEBT   = 4;
  localparam int DEF_DEBT_W     = 3;

endpackage

// File: rtl/cbr_detect.sv
// CAS-before-RAS detector on the observed DRAM pins; detect is combinational from the
// registered nRAS and the live pins, no backpressure (pins are only watched).
module cbr_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic nRAS,
  input  logic nCAS,
  output logic detect
);

  logic nRASr;

  always_ff @(posedge CLK) begin
    if (RESET) nRASr <= 1'b1;
    else       nRASr <= nRAS;
  end

  // RAS falling while CAS is already low; a normal access has CAS still high here.
  assign detect = nRASr && !nRAS && !nCAS;

endmodule

// File: rtl/ram_refresh_timer.sv
// Refresh obligation timer: owes one refresh per period, requests/escalates, retires on CBR.
// Outputs are registered one cycle behind the FSM state; the controller paces via CBR cycles.
module ram_refresh_timer
  import ram_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int URG_DELAY  = DEF_URG_DELAY,
  parameter int URG_DEBT   = DEF_URG_DEBT,
  parameter int MAX_DEBT   = DEF_MAX_DEBT,
  parameter int DEBT_W     = DEF_DEBT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              nRAS,
  input  logic              nCAS,
  output logic              RefReq,
  output logic              RefUrg,
  output logic              RefDone,
  output logic              Overrun,
  output logic [DEBT_W-1:0] Debt
);

  localparam int TICK_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int WAIT_W = $clog2(URG_DELAY + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REF_PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(URG_DELAY - 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX  = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] DEBT_URG  = DEBT_W'(URG_DEBT);

  logic [TICK_W-1:0] tickCnt;
  logic [WAIT_W-1:0] waitCnt;
  logic              tick;
  logic              detect;
  logic              reqNext;
  logic              urgNext;
  refState_t         state;
  refState_t         stateNext;

  cbr_detect uCbrDetect (
    .CLK    (CLK),
    .RESET  (RESET),
    .nRAS   (nRAS),
    .nCAS   (nCAS),
    .detect (detect)
  );

  assign tick = (tickCnt == TICK_LAST);

  always_ff @(posedge CLK) begin
    if (RESET || tick) tickCnt <= '0;
    else               tickCnt <= tickCnt + 1'b1;
  end

  // A tick and a CBR in the same cycle cancel out.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Debt    <= '0;
      Overrun <= 1'b0;
    end else if (tick && !detect) begin
      if (Debt != DEBT_MAX) Debt <= Debt + 1'b1;
      if (Debt >= DEBT_MAX - 1'b1) Overrun <= 1'b1;
    end else if (detect && !tick && (Debt != '0)) begin
      Debt <= Debt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      waitCnt <= '0;
      RefReq  <= 1'b0;
      RefUrg  <= 1'b0;
      RefDone <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= (state == REQ) ? waitCnt + 1'b1 : '0;
      RefReq  <= reqNext;
      RefUrg  <= urgNext;
      RefDone <= detect;
    end
  end

  // GAP forces one low cycle of RefReq so the controller can clear its done latch.
  always_comb begin
    stateNext = state;
    reqNext   = 1'b0;
    urgNext   = 1'b0;
    case (state)
      IDLE: begin
        if (Debt != '0) stateNext = REQ;
      end
      REQ: begin
        reqNext = 1'b1;
        if (detect)                                         stateNext = GAP;
        else if ((waitCnt == WAIT_LAST) || (Debt >= DEBT_URG)) stateNext = URG;
      end
      URG: begin
        reqNext = 1'b1;
        urgNext = 1'b1;
        if (detect) stateNext = GAP;
      end
      GAP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_refresh_timer.sv
// Directed bench: stimulus queues hand-computed checkpoints by cycle, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_ram_refresh_timer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       nRAS = 1'b1;
  logic       nCAS = 1'b1;
  logic       RefReq;
  logic       RefUrg;
  logic       RefDone;
  logic       Overrun;
  logic [2:0] Debt;

  typedef struct {
    int         cyc;
    string      name;
    logic       req;
    logic       urg;
    logic       done;
    logic       ovr;
    logic [2:0] debt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   base = 0;
  int   nCmp = 0;
  int   nErr = 0;
  int   donePulses = 0;

  ram_refresh_timer #(
    .REF_PERIOD (16),
    .URG_DELAY  (4),
    .URG_DEBT   (2),
    .MAX_DEBT   (4),
    .DEBT_W     (3)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .nRAS    (nRAS),
    .nCAS    (nCAS),
    .RefReq  (RefReq),
    .RefUrg  (RefUrg),
    .RefDone (RefDone),
    .Overrun (Overrun),
    .Debt    (Debt)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Expected outputs as seen after the current posedge.
  task automatic chk(input string nm, input logic r, input logic u, input logic d,
                     input logic o, input logic [2:0] db);
    exp_t x;
    x.cyc  = cyc;
    x.name = nm;
    x.req  = r;
    x.urg  = u;
    x.done = d;
    x.ovr  = o;
    x.debt = db;
    q.push_back(x);
  endtask

  // Advance to just after posedge number t counted from reset release.
  task automatic goto(input int t);
    while (cyc < base + t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  always @(negedge CLK) begin
    if (RefDone === 1'b1) donePulses++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      nCmp++;
      if (e.cyc != cyc) begin
        nErr++;
        $display("FAIL %s: checkpoint for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else if ({RefReq, RefUrg, RefDone, Overrun, Debt} !== {e.req, e.urg, e.done, e.ovr, e.debt}) begin
        nErr++;
        $display("FAIL %s: got req=%b urg=%b done=%b ovr=%b debt=%0d, want req=%b urg=%b done=%b ovr=%b debt=%0d",
                 e.name, RefReq, RefUrg, RefDone, Overrun, Debt, e.req, e.urg, e.done, e.ovr, e.debt);
      end
    end
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    base  = cyc;
    RESET = 1'b0;
    //  name            req urg done ovr debt
    chk("reset",        0,  0,  0,   0,  3'd0);
    goto(15);  chk("idle15",       0, 0, 0, 0, 3'd0);
    goto(16);  chk("tick1_debt",   0, 0, 0, 0, 3'd1);
    goto(17);  chk("req_lag",      0, 0, 0, 0, 3'd1);
    goto(18);  chk("req_high",     1, 0, 0, 0, 3'd1);
    nCAS = 1'b0;
    goto(19);  nRAS = 1'b0;
    goto(20);  chk("cbr_done",     1, 0, 1, 0, 3'd0);
    nRAS = 1'b1; nCAS = 1'b1;
    goto(21);  chk("gap_low",      0, 0, 0, 0, 3'd0);
    goto(22);  chk("stay_low",     0, 0, 0, 0, 3'd0);
    // Surplus CBR while idle with no debt.
    goto(24);  nCAS = 1'b0;
    goto(25);  nRAS = 1'b0;
    goto(26);  chk("surplus_done", 0, 0, 1, 0, 3'd0);
    nRAS = 1'b1; nCAS = 1'b1;
    goto(27);  chk("surplus_idle", 0, 0, 0, 0, 3'd0);
    // Second obligation; normal access during REQ must not count.
    goto(34);  chk("req2_high",    1, 0, 0, 0, 3'd1);
    nRAS = 1'b0;
    goto(35);  chk("normal_acc",   1, 0, 0, 0, 3'd1);
    nRAS = 1'b1;
    goto(37);  chk("pre_urg",      1, 0, 0, 0, 3'd1);
    goto(38);  chk("urg_wait",     1, 1, 0, 0, 3'd1);
    goto(48);  chk("urg_debt2",    1, 1, 0, 0, 3'd2);
    goto(50);  chk("urg_hold",     1, 1, 0, 0, 3'd2);
    goto(79);  chk("debt3",        1, 1, 0, 0, 3'd3);
    goto(80);  chk("overrun",      1, 1, 0, 1, 3'd4);
    goto(96);  chk("saturate",     1, 1, 0, 1, 3'd4);
    goto(97);  nCAS = 1'b0;
    goto(98);  nRAS = 1'b0;
    goto(99);  chk("cbr_at_max",   1, 1, 1, 1, 3'd3);
    nRAS = 1'b1; nCAS = 1'b1;
    goto(100); chk("gap2",         0, 0, 0, 1, 3'd3);
    goto(101); chk("idle2",        0, 0, 0, 1, 3'd3);
    goto(102); chk("rereq",        1, 0, 0, 1, 3'd3);
    goto(103); chk("reurg_debt",   1, 1, 0, 1, 3'd3);
    // CBR lands on the same cycle as the tick at 112.
    goto(110); nCAS = 1'b0;
    goto(111); nRAS = 1'b0;
    goto(112); chk("cbr_tick",     1, 1, 1, 1, 3'd3);
    nRAS = 1'b1; nCAS = 1'b1;
    goto(113); chk("gap3",         0, 0, 0, 1, 3'd3);
    goto(114); chk("idle3",        0, 0, 0, 1, 3'd3);
    goto(115); chk("req3",         1, 0, 0, 1, 3'd3);
    goto(116); chk("urg3",         1, 1, 0, 1, 3'd3);
    RESET = 1'b1;
    goto(117); chk("mid_reset",    0, 0, 0, 0, 3'd0);
    RESET = 1'b0;
    goto(132); chk("post_rst15",   0, 0, 0, 0, 3'd0);
    goto(133); chk("post_rst_tick",0, 0, 0, 0, 3'd1);
    goto(135); chk("post_rst_req", 1, 0, 0, 0, 3'd1);
    goto(140);
    @(negedge CLK);
    #1;
    nCmp++;
    if (q.size() != 0) begin
      nErr++;
      $display("FAIL queue_drain: %0d checkpoints left, want 0", q.size());
    end
    nCmp++;
    if (donePulses != 4) begin
      nErr++;
      $display("FAIL done_count: got %0d RefDone pulses, want 4", donePulses);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
